// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant table and key-schedule state type.
// Build option: AES_INV_KS_SBOX_REG_EN adds the CALC state for a registered S-box.
package aes_pkg;

    localparam int Nr          = 10;
    localparam int Nk          = 4;
    localparam int WORD_LENGTH = 32;
    localparam int KEY_BITS    = Nk * WORD_LENGTH;

    typedef logic [WORD_LENGTH-1:0] word_t;

    localparam logic [7:0] RCON [0:Nr] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

`ifdef AES_INV_KS_SBOX_REG_EN
    typedef enum logic [1:0] {IDLE, EMIT, CALC} ks_state_t;
`else
    typedef enum logic {IDLE, EMIT} ks_state_t;
`endif

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in and one byte out, purely combinational.
// Shared between the key schedule and the encryption datapath.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup; entry 0 occupies the most significant byte.
    always_comb begin
        dout = SBOX[2047 - 8 * int'(din) -: 8];
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: walks round keys 10 down to 0, one per handshake.
// Build option: AES_INV_KS_SBOX_REG_EN registers SubWord and inserts a CALC cycle.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_LENGTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KEY_LENGTH-1:0] last_key,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [KEY_LENGTH-1:0] round_key,
    output logic [3:0]            round_idx,
    output logic                  busy,
    output logic                  done
);

    ks_state_t             state_q;
    ks_state_t             state_d;
    logic [KEY_LENGTH-1:0] key_q;
    logic [3:0]            idx_q;
    logic                  done_q;

    word_t c3, c2, c1, c0;
    word_t p3, p2, p1, p0;
    word_t rot;
    word_t sub;
    word_t sub_use;

    logic hs;
    logic last_rnd;
    logic advance;

    assign c3 = key_q[127:96];
    assign c2 = key_q[95:64];
    assign c1 = key_q[63:32];
    assign c0 = key_q[31:0];

    assign p3  = c3 ^ c2;
    assign p2  = c2 ^ c1;
    assign p1  = c1 ^ c0;
    assign rot = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox3 (.din(rot[31:24]), .dout(sub[31:24]));
    aes_sbox u_sbox2 (.din(rot[23:16]), .dout(sub[23:16]));
    aes_sbox u_sbox1 (.din(rot[15:8]),  .dout(sub[15:8]));
    aes_sbox u_sbox0 (.din(rot[7:0]),   .dout(sub[7:0]));

    assign hs       = (state_q == EMIT) && rk_ready;
    assign last_rnd = (idx_q == 4'd0);

`ifdef AES_INV_KS_SBOX_REG_EN
    word_t sub_q;

    // Capture SubWord every cycle; the key is frozen through EMIT->CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub;
        end
    end

    assign sub_use = sub_q;
    assign advance = (state_q == CALC);
`else
    assign sub_use = sub;
    assign advance = hs && !last_rnd;
`endif

    assign p0 = c0 ^ sub_use ^ {RCON[idx_q], 24'h0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = EMIT;
            end
            EMIT: begin
                if (hs && last_rnd) state_d = IDLE;
`ifdef AES_INV_KS_SBOX_REG_EN
                else if (hs) state_d = CALC;
            end
            CALC: begin
                state_d = EMIT;
            end
`else
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Handshake-facing outputs decoded from the state.
    always_comb begin
        rk_valid = (state_q == EMIT);
        busy     = (state_q != IDLE);
    end

    // Current key, round number and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= hs && last_rnd;
            if (state_q == IDLE && start) begin
                key_q <= last_key;
                idx_q <= 4'(Nr);
            end else if (advance) begin
                key_q <= {p3, p2, p1, p0};
                idx_q <= idx_q - 4'd1;
            end
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed and round-trip bench for the reverse AES-128 key schedule.
// Honours AES_INV_KS_SBOX_REG_EN for the expected start-to-done latency.
module tb_aes_inv_key_schedule;

`ifdef AES_INV_KS_SBOX_REG_EN
    localparam int EXP_CYC = 22;
`else
    localparam int EXP_CYC = 12;
`endif

    localparam logic [127:0] A1_KEY = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] A1_R10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
    localparam logic [127:0] A1_R9  = 128'h575c006e_28d12941_19fadc21_ac7766f3;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] sched [0:10];

    aes_inv_key_schedule #(.KEY_LENGTH(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_sbox(input logic [7:0] b);
        return TB_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] tb_rcon(input int r);
        case (r)
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h04;
            4: return 8'h08;
            5: return 8'h10;
            6: return 8'h20;
            7: return 8'h40;
            8: return 8'h80;
            9: return 8'h1b;
            10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]),
                tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    // Forward FIPS-197 expansion into sched[0..10].
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = ck[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {tb_rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            sched[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_valid"}, 128'(rk_valid), 128'(0));
        check_eq({tag, "_key"}, round_key, 128'(0));
        check_eq({tag, "_idx"}, 128'(round_idx), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_done"}, 128'(done), 128'(0));
    endtask

    // mode 0: ready high, 1: random ready, 2: start at round 5, 3: reset at round 6
    task automatic walk(input logic [127:0] ck, input int mode, input bit a1);
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        bit           prev_stall;
        bit           injected;
        int           cyc;
        int           exp_idx;
        expand(ck);
        rk_ready = 1'b1;
        start    = 1'b1;
        last_key = sched[10];
        @(posedge clk); #1;
        start    = 1'b0;
        last_key = ~sched[10];
        cyc        = 1;
        exp_idx    = 10;
        prev_stall = 1'b0;
        injected   = 1'b0;
        prev_key   = '0;
        prev_idx   = '0;
        check_eq("first_valid", 128'(rk_valid), 128'(1));
        check_eq("first_busy", 128'(busy), 128'(1));
        while (!done && cyc < 200) begin
            if (prev_stall) begin
                check_eq("stall_key", round_key, prev_key);
                check_eq("stall_idx", 128'(round_idx), 128'(prev_idx));
            end
            if (mode == 3 && rk_valid && round_idx == 4'd6) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_outs("midrst");
                return;
            end
            start = 1'b0;
            if (mode == 2 && !injected && rk_valid && round_idx == 4'd5) begin
                start    = 1'b1;
                last_key = 128'h0123456789abcdef_fedcba9876543210;
                injected = 1'b1;
            end
            rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
                check_eq("rk_idx", 128'(round_idx), 128'(exp_idx));
                check_eq("rk_key", round_key, sched[exp_idx]);
                if (a1 && exp_idx == 10) check_eq("a1_round10", round_key, A1_R10);
                if (a1 && exp_idx == 9) check_eq("a1_round9", round_key, A1_R9);
                if (a1 && exp_idx == 0) check_eq("a1_round0", round_key, A1_KEY);
                exp_idx--;
            end
            prev_stall = rk_valid && !rk_ready;
            prev_key   = round_key;
            prev_idx   = round_idx;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        check_eq("walk_done", 128'(done), 128'(1));
        check_eq("all_rounds", 128'(exp_idx + 1), 128'(0));
        check_eq("done_busy", 128'(busy), 128'(0));
        if (a1) check_eq("cycles", 128'(cyc), 128'(EXP_CYC));
        @(posedge clk); #1;
        check_eq("done_pulse", 128'(done), 128'(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst      = 1'b0;
        rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("idle_ready");

        walk(A1_KEY, 0, 1'b1);
        walk(A1_KEY, 1, 1'b0);
        walk(A1_KEY, 3, 1'b0);
        walk(A1_KEY, 0, 1'b1);
        walk(128'h00112233_44556677_8899aabb_ccddeeff, 2, 1'b0);
        for (int k = 0; k < 100; k++) begin
            walk({$urandom, $urandom, $urandom, $urandom}, (k % 4 == 0) ? 1 : 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Reverse AES-128 key schedule. It takes the last round key (round 10, words w40..w43) and walks the schedule backwards, one round key per handshake, from round 10 down to round 0, which is the original cipher key. The block feeds the decryption datapath, which needs round keys in the reverse order to the forward expansion. Because it regenerates keys on the fly, the decryptor needs no 1408-bit schedule store.

## Interface
- KEY_LENGTH, 128: key and round-key width; only 128 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; load last_key. Honoured only in IDLE.
- last_key  in  KEY_LENGTH  round-10 key. Word j sits at [32*j +: 32]. Within a word, FIPS byte 0 sits at [31:24].
- rk_valid  out  1  round_key is valid.
- rk_ready  in  1  consumer accepts round_key when rk_valid && rk_ready.
- round_key  out  KEY_LENGTH  current round key, same packing as last_key.
- round_idx  out  4  round number of round_key, 10..0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the cycle after round 0 is accepted.

## Operation
- States: IDLE, EMIT, and CALC (CALC exists only with the macro below).
- IDLE + start: register last_key into the current key c3..c0 and set round_idx=10. Go to EMIT.
- EMIT: rk_valid=1 and round_key={c3,c2,c1,c0}. Hold both stable until the handshake.
- Handshake with round_idx>0: replace the current key with the previous round key p and decrement round_idx. Without the macro, stay in EMIT.
- Handshake with round_idx==0: go to IDLE and pulse done on the next cycle.
- Previous-round derivation for current round r:
  - p3=c3^c2; p2=c2^c1; p1=c1^c0.
  - p0=c0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
  - RotWord(w)={w[23:0],w[31:24]}.
  - SubWord applies the forward AES S-box to each byte.
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36.
- Arithmetic is XOR only; all widths are exact, with no overflow cases.
- start while busy: ignored; the current walk continues unchanged.
- rk_ready held low: the block stalls indefinitely and round_key stays stable.
- rk_ready high in IDLE: no effect.
- rst at any time, including mid-walk: next state IDLE.

## Timing
- Reset values: rk_valid=0, round_key=0, round_idx=0, busy=0, done=0.
- start in cycle t: rk_valid=1 with round 10 in cycle t+1. busy=1 from t+1.
- Without the macro:
  - One round key per cycle under continuous rk_ready.
  - Round 0 is presented at t+11.
  - done pulses at t+12.
- With the macro:
  - After each non-final handshake, rk_valid drops for one cycle (CALC) and the next key appears in the following cycle.
  - Round 0 is presented at t+21.
  - done pulses at t+22.
- done and a new start may coincide: start is honoured because the state is already IDLE.

## Configuration
- AES_INV_KS_SBOX_REG_EN:
  - Defined: the SubWord output is registered. After each non-final handshake the FSM enters CALC for one cycle, during which rk_valid=0, then returns to EMIT with the new key. This shortens the critical path.
  - Undefined: the S-box path is combinational and CALC does not exist.

## Structure
- Shared package aes_pkg holds:
  - constants Nr=10, Nk=4 and WORD_LENGTH=32;
  - the Rcon table indexed by round;
  - the state enum typedef.
- Sub-module aes_sbox: byte in, byte out, forward S-box. It is instantiated four times for SubWord and is shared with the encryption path.

## Test plan
- FIPS-197 A.1 walk: start with last_key=128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8 and rk_ready=1.
  - Round 9 -> round_key=128'h575c006e_28d12941_19fadc21_ac7766f3.
  - Round 0 -> 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516.
  - done is a single pulse.
- Backpressure: random rk_ready.
  - round_key and round_idx never change while rk_valid && !rk_ready.
  - The sequence matches the free-running run.
- Mid-walk reset: rst at round 6.
  - Next cycle all outputs equal their reset values.
  - A fresh start then yields the full 10..0 sequence.
- Start while busy: second start with a different key at round 5. It is ignored and the original sequence completes.
- Round trip: 100 random cipher keys.
  - Expand each forward with the reference model.
  - Feed w40..w43 to the block.
  - Every round key matches the model's schedule in reverse.
- Both configurations: run the FIPS-197 A.1 walk with and without AES_INV_KS_SBOX_REG_EN.
  - Cycle counts are 12 and 22 respectively from start to done.
